imem_load_ctrl: RTL
===================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter AW, default 6, meaning instruction-memory address width (64 words).
REQ-002 Parameter DW, default 32, meaning instruction word width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle load request.
REQ-006 abort  input  1  single-cycle cancel of an in-progress load.
REQ-007 base_addr  input  AW  first memory word to write; sampled on accepted start.
REQ-008 word_count  input  AW+1  number of words to load, legal range 1..2^AW; sampled on accepted start.
REQ-009 s_valid  input  1  host word valid.
REQ-010 s_data  input  DW  host word.
REQ-011 s_ready  output  1  controller can accept a host word.
REQ-012 mem_we  output  1  instruction-memory write enable.
REQ-013 mem_waddr  output  AW  instruction-memory write address.
REQ-014 mem_wdata  output  DW  instruction-memory write data.
REQ-015 cpu_stall  output  1  holds the fetch stage while memory is being rewritten.
REQ-016 busy  output  1  controller not in IDLE.
REQ-017 done  output  1  single-cycle pulse: load finished.
REQ-018 err  output  1  single-cycle pulse: illegal request or abort.
REQ-019 checksum  output  DW  running sum of loaded words.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-021 In IDLE, start with word_count in 1..2^AW SHALL latch base_addr and word_count, clear checksum and enter LOAD next cycle.
REQ-022 In IDLE, start with word_count 0 or above 2^AW SHALL pulse err next cycle and stay in IDLE.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 s_ready SHALL equal 1 exactly when the state is LOAD.
REQ-025 A handshake SHALL occur when s_valid and s_ready are both 1; s_data is captured in that cycle.
REQ-026 Each handshake SHALL produce mem_we=1 for exactly one cycle, one cycle later.
REQ-027 In that write cycle, mem_waddr SHALL equal the current write pointer and mem_wdata the captured word.
REQ-028 The write pointer SHALL start at base_addr and increment by 1 per handshake, wrapping from 2^AW-1 to 0.
REQ-029 checksum SHALL add each captured word, modulo 2^DW, registered in the same cycle as the matching mem_we.
REQ-030 The handshake that completes word_count words SHALL move the FSM to DONE.
REQ-031 DONE SHALL last one cycle: done=1 in that cycle, which coincides with the last mem_we, then return to IDLE.
REQ-032 s_valid low in LOAD SHALL stall the load indefinitely with no write and no state change.
REQ-033 abort in LOAD SHALL return the FSM to IDLE next cycle and pulse err in that cycle.
REQ-034 On abort, done SHALL not pulse, and checksum SHALL keep the value of the words already written.
REQ-035 abort coincident with a handshake SHALL win: the word is not written and not summed.
REQ-036 abort in IDLE or DONE SHALL be ignored.
REQ-037 cpu_stall SHALL be 1 from the cycle after an accepted start through the DONE cycle inclusive, and 0 otherwise.
REQ-038 busy SHALL be 1 in LOAD and DONE.

Reset
REQ-039 rst_n low SHALL immediately force IDLE and drive s_ready, mem_we, cpu_stall, busy, done and err to 0.
REQ-040 rst_n low SHALL also clear mem_waddr, mem_wdata, checksum and the internal counters to 0.
REQ-041 Reset mid-load SHALL discard the load with no done or err pulse; words already written stay in memory.

Structure
REQ-042 FSM state encodings, AW and DW defaults SHALL live in a shared package mips_pkg.
REQ-043 The address and remaining-count logic SHALL be one sub-module, imem_wr_ptr, with load, increment, wrap and last-word flag.
REQ-044 The memory array itself SHALL stay outside this block; only the write port is driven.

Verification
REQ-045 Basic load: base_addr=0, word_count=4, 4 back-to-back words 0x1..0x4 -> mem_we at addr 0..3, done 1 cycle after the 4th handshake, checksum=0xA.
REQ-046 Wrap: base_addr=62, word_count=4 -> write addresses 62, 63, 0, 1.
REQ-047 Illegal count: word_count=0 and word_count=65 -> err pulse, busy stays 0, no mem_we.
REQ-048 Abort collision: abort on the same cycle as the 2nd handshake of 5 -> 1 write only, err pulse, IDLE, cpu_stall drops.
REQ-049 Throttled host: s_valid toggling 1,0,0,1 for word_count=2 -> exactly 2 writes, cpu_stall held high throughout.
REQ-050 Async reset: rst_n low mid-load between clock edges -> outputs 0 immediately, a new start is accepted after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: default geometry
// and the load FSM state encoding.
package mips_pkg;

    localparam int unsigned IMEM_AW = 6;
    localparam int unsigned IMEM_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/imem_wr_ptr.sv
// Write pointer and remaining-word counter for the instruction-memory loader.
// The pointer wraps naturally at 2^AW; last flags the final word of a load.
module imem_wr_ptr
    import mips_pkg::*;
#(
    parameter int unsigned AW = IMEM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    output logic [AW-1:0] ptr,
    output logic          last
);

    logic [AW:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
        end else if (load) begin
            ptr       <= base_addr;
            remaining <= count;
        end else if (inc) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    assign last = (remaining == {{AW{1'b0}}, 1'b1});

endmodule

// File: rtl/imem_load_ctrl.sv
// Streams host words into the instruction memory write port while stalling
// the CPU fetch stage; supports abort and reports a running checksum.
module imem_load_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned AW = IMEM_AW,
    parameter int unsigned DW = IMEM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   word_count,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_stall,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] checksum
);

    localparam logic [AW:0] MAX_COUNT = {1'b1, {AW{1'b0}}};

    load_state_t   state, state_nxt;
    logic          count_ok;
    logic          accept;
    logic          reject;
    logic          aborting;
    logic          hs;
    logic          last;
    logic [AW-1:0] ptr;

    assign count_ok = (word_count != '0) && (word_count <= MAX_COUNT);
    assign accept   = (state == ST_IDLE) && start && count_ok;
    assign reject   = (state == ST_IDLE) && start && !count_ok;
    assign aborting = (state == ST_LOAD) && abort;
    // abort takes priority over a coincident handshake
    assign hs       = (state == ST_LOAD) && s_valid && !abort;

    imem_wr_ptr #(.AW(AW)) u_wr_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .inc       (hs),
        .base_addr (base_addr),
        .count     (word_count),
        .ptr       (ptr),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        cpu_stall = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready   = 1'b1;
                busy      = 1'b1;
                cpu_stall = 1'b1;
                if (aborting)      state_nxt = ST_IDLE;
                else if (hs && last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                cpu_stall = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write port and checksum trail the handshake by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            checksum  <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= hs;
            err    <= reject || aborting;
            if (hs) begin
                mem_waddr <= ptr;
                mem_wdata <= s_data;
                checksum  <= checksum + s_data;
            end else if (accept) begin
                checksum  <= '0;
            end
        end
    end

endmodule
